// File: rtl/sram_pkg.sv
// Shared definitions for the external async SRAM bus model:
// bus widths and the per-edge cycle classification.
package sram_pkg;

   localparam int unsigned SRAM_ADDR_W = 18;
   localparam int unsigned SRAM_DATA_W = 16;

   typedef enum logic [1:0] {
      CYC_IDLE,
      CYC_READ,
      CYC_WRITE
   } cyc_class_e;

   // WE_N dominates OE_N, so a write with OE_N low is still a write.
   function automatic cyc_class_e decode_cycle(input logic ce_n, input logic oe_n,
                                               input logic we_n);
      if (ce_n)  return CYC_IDLE;
      if (!we_n) return CYC_WRITE;
      if (!oe_n) return CYC_READ;
      return CYC_IDLE;
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Fixed-depth shift register carrying sampled read requests {valid, addr, ub_n, lb_n}
// from the address-sample edge to the DQ drive point.
module sram_rd_pipe #(
   parameter int unsigned LAT    = 1,
   parameter int unsigned ADDR_W = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   input  logic [ADDR_W-1:0] in_addr_i,
   input  logic              in_ub_n_i,
   input  logic              in_lb_n_i,
   output logic              out_valid_o,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic              out_ub_n_o,
   output logic              out_lb_n_o
);

   logic [LAT-1:0]    valid_q;
   logic [LAT-1:0]    ub_n_q;
   logic [LAT-1:0]    lb_n_q;
   logic [ADDR_W-1:0] addr_q [LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         ub_n_q  <= '1;
         lb_n_q  <= '1;
         for (int unsigned i = 0; i < LAT; i++) addr_q[i] <= '0;
      end else begin
         valid_q[0] <= in_valid_i;
         ub_n_q[0]  <= in_ub_n_i;
         lb_n_q[0]  <= in_lb_n_i;
         addr_q[0]  <= in_addr_i;
         for (int unsigned i = 1; i < LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            ub_n_q[i]  <= ub_n_q[i-1];
            lb_n_q[i]  <= lb_n_q[i-1];
            addr_q[i]  <= addr_q[i-1];
         end
      end
   end

   assign out_valid_o = valid_q[LAT-1];
   assign out_ub_n_o  = ub_n_q[LAT-1];
   assign out_lb_n_o  = lb_n_q[LAT-1];
   assign out_addr_o  = addr_q[LAT-1];

endmodule

// File: rtl/sram_device_model.sv
// Pin-level stand-in for the 256K x 16 async SRAM: word array, byte-lane writes,
// optional registered read latency, access counters and a sticky out-of-range flag.
module sram_device_model
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W    = SRAM_ADDR_W,
  parameter int unsigned DATA_W    = SRAM_DATA_W,
  parameter int unsigned DEPTH     = 262144,
  parameter int unsigned READ_LAT  = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic              addr_oob
);

  localparam int unsigned     HALF    = DATA_W / 2;
  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  cyc_class_e        cyc;
  logic              rd_now;
  logic              acc_oob;
  logic [IDX_W-1:0]  wr_idx;

  assign cyc     = decode_cycle(SRAM_CE_N, SRAM_OE_N, SRAM_WE_N);
  assign rd_now  = (cyc == CYC_READ);
  assign acc_oob = ({1'b0, SRAM_ADDR} >= DEPTH_L);
  assign wr_idx  = SRAM_ADDR[IDX_W-1:0];

  // Out-of-range writes are dropped so the truncated index cannot alias a real word.
  always_ff @(posedge clk) begin
    if (!rst && cyc == CYC_WRITE && !acc_oob) begin
      if (!SRAM_UB_N) mem[wr_idx][DATA_W-1:HALF] <= SRAM_DQ[DATA_W-1:HALF];
      if (!SRAM_LB_N) mem[wr_idx][HALF-1:0]      <= SRAM_DQ[HALF-1:0];
    end
  end

  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;
  logic        addr_oob_q, addr_oob_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    addr_oob_d = addr_oob_q;
    if (cyc == CYC_READ)  rd_count_d = rd_count_q + 32'd1;
    if (cyc == CYC_WRITE) wr_count_d = wr_count_q + 32'd1;
    if (cyc != CYC_IDLE && acc_oob) addr_oob_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
      addr_oob_q <= 1'b0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      addr_oob_q <= addr_oob_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
  assign addr_oob = addr_oob_q;

  logic              rq_valid;
  logic [ADDR_W-1:0] rq_addr;
  logic              rq_ub_n;
  logic              rq_lb_n;

  if (READ_LAT == 0) begin : g_async
    assign rq_valid = rd_now;
    assign rq_addr  = SRAM_ADDR;
    assign rq_ub_n  = SRAM_UB_N;
    assign rq_lb_n  = SRAM_LB_N;
  end else begin : g_pipe
    sram_rd_pipe #(
      .LAT    (READ_LAT),
      .ADDR_W (ADDR_W)
    ) u_rd_pipe (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (rd_now),
      .in_addr_i   (SRAM_ADDR),
      .in_ub_n_i   (SRAM_UB_N),
      .in_lb_n_i   (SRAM_LB_N),
      .out_valid_o (rq_valid),
      .out_addr_o  (rq_addr),
      .out_ub_n_o  (rq_ub_n),
      .out_lb_n_o  (rq_lb_n)
    );
  end

  // A matured request only drives while the bus is still presenting a read right now.
  logic              drv_en;
  logic              rq_oob;
  logic [DATA_W-1:0] rd_word;

  assign drv_en  = rd_now & rq_valid;
  assign rq_oob  = ({1'b0, rq_addr} >= DEPTH_L);
  assign rd_word = rq_oob ? 'x : mem[rq_addr[IDX_W-1:0]];

  assign SRAM_DQ[DATA_W-1:HALF] = (drv_en && !rq_ub_n) ? rd_word[DATA_W-1:HALF] : 'z;
  assign SRAM_DQ[HALF-1:0]      = (drv_en && !rq_lb_n) ? rd_word[HALF-1:0]      : 'z;

endmodule

// File: tb/tb_sram_device_model.sv
// Directed bench: one async-read and one two-stage-read instance share the control bus;
// pulled-up DQ nets make an undriven lane read back as 8'hFF.
module tb_sram_device_model;

   logic        clk = 1'b0;
   logic        rst;
   logic [17:0] addr;
   logic        ce_n, oe_n, we_n, ub_n, lb_n;
   logic        tb_oe;
   logic [15:0] tb_dq;

   tri1 [15:0] dq0;
   tri1 [15:0] dq2;

   assign dq0 = tb_oe ? tb_dq : 16'hzzzz;
   assign dq2 = tb_oe ? tb_dq : 16'hzzzz;

   logic [31:0] rdc0, wrc0, rdc2, wrc2;
   logic        oob0, oob2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sram_device_model #(
      .READ_LAT (0),
      .DEPTH    (1024)
   ) u0 (
      .clk       (clk),
      .rst       (rst),
      .SRAM_ADDR (addr),
      .SRAM_DQ   (dq0),
      .SRAM_CE_N (ce_n),
      .SRAM_OE_N (oe_n),
      .SRAM_WE_N (we_n),
      .SRAM_UB_N (ub_n),
      .SRAM_LB_N (lb_n),
      .rd_count  (rdc0),
      .wr_count  (wrc0),
      .addr_oob  (oob0)
   );

   sram_device_model #(
      .READ_LAT (2),
      .DEPTH    (1024)
   ) u2 (
      .clk       (clk),
      .rst       (rst),
      .SRAM_ADDR (addr),
      .SRAM_DQ   (dq2),
      .SRAM_CE_N (ce_n),
      .SRAM_OE_N (oe_n),
      .SRAM_WE_N (we_n),
      .SRAM_UB_N (ub_n),
      .SRAM_LB_N (lb_n),
      .rd_count  (rdc2),
      .wr_count  (wrc2),
      .addr_oob  (oob2)
   );

   typedef struct {
      logic        ce_n, oe_n, we_n, ub_n, lb_n;
      logic [17:0] a;
      logic        drv;
      logic [15:0] w;
      logic        chk;
      logic [15:0] exp;
   } vec_t;

   function automatic vec_t mkv(input logic c, input logic o, input logic we,
                                input logic u, input logic l, input logic [17:0] a,
                                input logic d, input logic [15:0] w,
                                input logic k, input logic [15:0] e);
      vec_t v;
      v.ce_n = c; v.oe_n = o; v.we_n = we; v.ub_n = u; v.lb_n = l;
      v.a = a; v.drv = d; v.w = w; v.chk = k; v.exp = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one bus cycle just after the rising edge.
   task automatic bus(input logic c, input logic o, input logic we, input logic u,
                      input logic l, input logic [17:0] a, input logic d,
                      input logic [15:0] w);
      @(posedge clk);
      #1;
      ce_n = c; oe_n = o; we_n = we; ub_n = u; lb_n = l;
      addr = a; tb_oe = d; tb_dq = w;
   endtask

   task automatic idle();
      bus(1, 1, 1, 1, 1, 18'h0, 0, 16'h0);
   endtask

   task automatic rd(input logic [17:0] a);
      bus(0, 0, 1, 0, 0, a, 0, 16'h0);
   endtask

   task automatic wr(input logic [17:0] a, input logic [15:0] w);
      bus(0, 1, 0, 0, 0, a, 1, w);
   endtask

   vec_t vecs[13];

   initial begin
      //           ce oe we ub lb addr      drv data      chk exp
      vecs[0]  = mkv(0, 1, 0, 0, 0, 18'h005, 1, 16'hBEEF, 0, 16'h0000);
      vecs[1]  = mkv(0, 0, 1, 0, 0, 18'h005, 0, 16'h0000, 1, 16'hBEEF);
      vecs[2]  = mkv(0, 1, 0, 0, 0, 18'h010, 1, 16'h1234, 0, 16'h0000);
      vecs[3]  = mkv(0, 1, 0, 1, 0, 18'h010, 1, 16'hABCD, 0, 16'h0000);
      vecs[4]  = mkv(0, 0, 1, 0, 0, 18'h010, 0, 16'h0000, 1, 16'h12CD);
      vecs[5]  = mkv(0, 0, 1, 0, 1, 18'h010, 0, 16'h0000, 1, 16'h12FF);
      vecs[6]  = mkv(0, 0, 1, 1, 0, 18'h010, 0, 16'h0000, 1, 16'hFFCD);
      vecs[7]  = mkv(0, 0, 0, 1, 1, 18'h005, 0, 16'h0000, 1, 16'hFFFF);
      vecs[8]  = mkv(0, 0, 0, 0, 0, 18'h030, 1, 16'h7777, 0, 16'h0000);
      vecs[9]  = mkv(1, 0, 1, 0, 0, 18'h005, 0, 16'h0000, 1, 16'hFFFF);
      vecs[10] = mkv(0, 1, 1, 0, 0, 18'h005, 0, 16'h0000, 1, 16'hFFFF);
      vecs[11] = mkv(0, 0, 1, 0, 0, 18'h030, 0, 16'h0000, 1, 16'h7777);
      vecs[12] = mkv(0, 0, 1, 0, 0, 18'h005, 0, 16'h0000, 1, 16'hBEEF);

      rst = 1; ce_n = 1; oe_n = 1; we_n = 1; ub_n = 1; lb_n = 1;
      addr = '0; tb_oe = 0; tb_dq = '0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("reset rd_count0", rdc0, 0);
      chk("reset wr_count0", wrc0, 0);
      chk("reset oob0", 32'(oob0), 0);
      chk("reset rd_count2", rdc2, 0);
      chk("reset wr_count2", wrc2, 0);
      chk("reset oob2", 32'(oob2), 0);
      chk("reset dq0", 32'(dq0), 32'hFFFF);
      chk("reset dq2", 32'(dq2), 32'hFFFF);

      for (int i = 0; i < 13; i++) begin
         bus(vecs[i].ce_n, vecs[i].oe_n, vecs[i].we_n, vecs[i].ub_n, vecs[i].lb_n,
             vecs[i].a, vecs[i].drv, vecs[i].w);
         @(negedge clk);
         if (vecs[i].chk) chk($sformatf("vec%0d dq0", i), 32'(dq0), 32'(vecs[i].exp));
      end
      idle();
      @(negedge clk);
      chk("table rd_count0", rdc0, 6);
      chk("table wr_count0", wrc0, 5);
      chk("table rd_count2", rdc2, 6);
      chk("table wr_count2", wrc2, 5);

      // Two-stage read latency, then OE_N release mid-read.
      wr(18'h020, 16'h5A5A);
      rd(18'h020); @(negedge clk);
      chk("lat0 c1 dq0", 32'(dq0), 32'h5A5A);
      chk("lat2 c1 dq2", 32'(dq2), 32'hFFFF);
      rd(18'h020); @(negedge clk);
      chk("lat2 c2 dq2", 32'(dq2), 32'hFFFF);
      rd(18'h020); @(negedge clk);
      chk("lat2 c3 dq2", 32'(dq2), 32'h5A5A);
      bus(0, 1, 1, 0, 0, 18'h020, 0, 16'h0); @(negedge clk);
      chk("lat2 oe drop dq2", 32'(dq2), 32'hFFFF);
      chk("lat rd_count2", rdc2, 9);
      chk("lat wr_count2", wrc2, 6);

      // Reset with a read in flight in the two-stage pipe.
      rd(18'h020);
      rd(18'h020); rst = 1;
      rd(18'h020); rst = 0;
      @(negedge clk);
      chk("rst flush dq2", 32'(dq2), 32'hFFFF);
      chk("rst rd_count2", rdc2, 0);
      chk("rst wr_count2", wrc2, 0);
      chk("rst rd_count0", rdc0, 0);
      chk("rst wr_count0", wrc0, 0);
      chk("rst keep 020", 32'(dq0), 32'h5A5A);
      idle(); @(negedge clk);
      chk("post rst rd_count0", rdc0, 1);
      chk("post rst rd_count2", rdc2, 1);
      rd(18'h005); @(negedge clk);
      chk("rst keep 005", 32'(dq0), 32'hBEEF);
      rd(18'h030); @(negedge clk);
      chk("rst keep 030", 32'(dq0), 32'h7777);

      // Out-of-range handling at DEPTH=1024.
      idle(); rst = 1;
      idle(); rst = 0;
      @(negedge clk);
      chk("oob clear0", 32'(oob0), 0);
      wr(18'h000, 16'h2468);
      wr(18'h3FF, 16'h1357);
      idle(); @(negedge clk);
      chk("oob last word0", 32'(oob0), 0);
      wr(18'h400, 16'h1111);
      idle(); @(negedge clk);
      chk("oob write0", 32'(oob0), 1);
      chk("oob write2", 32'(oob2), 1);
      chk("oob wr_count0", wrc0, 3);
      idle(); idle(); @(negedge clk);
      chk("oob sticky0", 32'(oob0), 1);
      rd(18'h000); @(negedge clk);
      chk("oob dropped 000", 32'(dq0), 32'h2468);
      rd(18'h3FF); @(negedge clk);
      chk("oob last word 3ff", 32'(dq0), 32'h1357);
      idle(); @(negedge clk);
      chk("oob rd_count0", rdc0, 2);
      idle(); rst = 1;
      idle(); rst = 0;
      @(negedge clk);
      chk("oob rst clear0", 32'(oob0), 0);
      chk("oob rst clear2", 32'(oob2), 0);
      rd(18'h7FF);
      idle(); @(negedge clk);
      chk("oob read0", 32'(oob0), 1);
      chk("oob read rd_count0", rdc0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
